// File: rtl/beat_pkg.sv
// Shared state encoding, note width and beat-rate derivation for the beat track recorder.
package beat_pkg;

    localparam int NOTE_W = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RECORD = 2'd1;
    localparam state_t ST_PLAY   = 2'd2;

    localparam logic [NOTE_W-1:0] REST_CODE = 7'h00;

    // Clock cycles per beat; callers must keep the result at 2 or more.
    function automatic int tick_div(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/beat_ram.sv
// Simple dual-port note store: one write port, one registered read port, no array reset.
module beat_ram
    import beat_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [NOTE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [NOTE_W-1:0] rdata
);

    logic [NOTE_W-1:0] mem_r [DEPTH];
    logic [NOTE_W-1:0] rdata_r;

    // Array write and synchronous read; left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/beat_track_recorder.sv
// Single-track note recorder/looper: samples the live note at the beat rate and replays it in a loop.
module beat_track_recorder
    import beat_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 16,
    parameter int DEPTH     = 256
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   record_req,
    input  logic                   play_req,
    input  logic [NOTE_W-1:0]      ascii_in,
    output logic [NOTE_W-1:0]      ascii_out,
    output logic                   recording,
    output logic                   playing,
    output logic                   full,
    output logic [$clog2(DEPTH):0] rec_len
);

    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = AW + 1;
    localparam int TICK_DIV = tick_div(CLK_HZ, SAMPLE_HZ);
    localparam int CW       = $clog2(TICK_DIV);

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LEN_FULL  = LW'(DEPTH);

    state_t            state_r, state_nxt_s;
    logic [CW-1:0]     cnt_r, cnt_nxt_s;
    logic [AW-1:0]     addr_r, addr_nxt_s;
    logic [LW-1:0]     rec_len_r, rec_len_nxt_s;
    logic              full_r, recording_r, playing_r;
    logic [NOTE_W-1:0] ascii_out_r;
    logic [NOTE_W-1:0] rd_data_s;
    logic              tick_s, enter_s, we_s, play_wrap_s;

    // Mode selection; a record request always wins over a play request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (record_req) begin
                    state_nxt_s = ST_RECORD;
                end else if (play_req && (rec_len_r != {LW{1'b0}})) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECORD: begin
                if (!record_req) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RECORD;
                end
            end
            ST_PLAY: begin
                if (record_req) begin
                    state_nxt_s = ST_RECORD;
                end else if (!play_req) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign tick_s      = (cnt_r == TICK_LAST);
    assign enter_s     = (state_nxt_s != state_r);
    assign we_s        = (state_r == ST_RECORD) && tick_s && !full_r;
    assign play_wrap_s = (({1'b0, addr_r} + LW'(1)) == rec_len_r);

    // Beat counter, shared address and length; the read port looks at the next address so data lands one cycle after it.
    always_comb begin
        cnt_nxt_s     = cnt_r + CW'(1);
        addr_nxt_s    = addr_r;
        rec_len_nxt_s = rec_len_r;
        if (enter_s || tick_s) begin
            cnt_nxt_s = {CW{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
        if (enter_s) begin
            addr_nxt_s = {AW{1'b0}};
        end else if (we_s) begin
            addr_nxt_s = addr_r + AW'(1);
        end else if ((state_r == ST_PLAY) && tick_s) begin
            addr_nxt_s = play_wrap_s ? {AW{1'b0}} : (addr_r + AW'(1));
        end else begin
            addr_nxt_s = addr_r;
        end
        // A write on the tick that ends recording still counts, so length is cleared only on entry.
        if (enter_s && (state_nxt_s == ST_RECORD)) begin
            rec_len_nxt_s = {LW{1'b0}};
        end else if (we_s) begin
            rec_len_nxt_s = rec_len_r + LW'(1);
        end else begin
            rec_len_nxt_s = rec_len_r;
        end
    end

    // State, counters and all outputs are registered; reset drops everything to idle at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            addr_r      <= {AW{1'b0}};
            rec_len_r   <= {LW{1'b0}};
            full_r      <= 1'b0;
            recording_r <= 1'b0;
            playing_r   <= 1'b0;
            ascii_out_r <= REST_CODE;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            addr_r      <= addr_nxt_s;
            rec_len_r   <= rec_len_nxt_s;
            full_r      <= (rec_len_nxt_s == LEN_FULL);
            recording_r <= (state_nxt_s == ST_RECORD);
            playing_r   <= (state_nxt_s == ST_PLAY);
            ascii_out_r <= ((state_r == ST_PLAY) && (state_nxt_s == ST_PLAY)) ? rd_data_s : REST_CODE;
        end
    end

    beat_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (addr_r),
        .wdata (ascii_in),
        .raddr (addr_nxt_s),
        .rdata (rd_data_s)
    );

    assign ascii_out = ascii_out_r;
    assign recording = recording_r;
    assign playing   = playing_r;
    assign full      = full_r;
    assign rec_len   = rec_len_r;

endmodule

// File: tb/tb_beat_track_recorder.sv
// Bench for beat_track_recorder: directed table rows, reset corner case and random stimulus against a reference model.
module tb_beat_track_recorder;

    localparam int DEPTH = 4;
    localparam int TDIV  = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       record_req;
    logic       play_req;
    logic [6:0] ascii_in;
    logic [6:0] ascii_out;
    logic       recording;
    logic       playing;
    logic       full;
    logic [2:0] rec_len;

    always #5 clk = ~clk;

    beat_track_recorder #(
        .CLK_HZ    (8),
        .SAMPLE_HZ (2),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .record_req (record_req),
        .play_req   (play_req),
        .ascii_in   (ascii_in),
        .ascii_out  (ascii_out),
        .recording  (recording),
        .playing    (playing),
        .full       (full),
        .rec_len    (rec_len)
    );

    // Reference model: mode, edges since the mode was entered, and the list of stored notes.
    typedef enum int {M_IDLE, M_REC, M_PLAY} mstate_e;
    mstate_e    m_state;
    int         m_el;
    int         m_len;
    logic [6:0] m_mem [DEPTH];

    int n_cmp;
    int n_bad;

    typedef struct {
        logic       r;
        logic       p;
        logic [6:0] a;
        int         n;
        logic [6:0] eo;
        logic       er;
        logic       ep;
        int         el;
        logic       ef;
    } row_t;

    row_t rows[$];

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_el    = 0;
        m_len   = 0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        mstate_e nxt;
        if (m_state == M_REC && ((m_el + 1) % TDIV) == 0 && m_len < DEPTH) begin
            m_mem[m_len] = ascii_in;
            m_len++;
        end
        nxt = m_state;
        case (m_state)
            M_IDLE: begin
                if (record_req) nxt = M_REC;
                else if (play_req && m_len != 0) nxt = M_PLAY;
            end
            M_REC: begin
                if (!record_req) nxt = M_IDLE;
            end
            default: begin
                if (record_req) nxt = M_REC;
                else if (!play_req) nxt = M_IDLE;
            end
        endcase
        if (nxt != m_state) begin
            m_el = 0;
            if (nxt == M_REC) m_len = 0;
        end else begin
            m_el++;
        end
        m_state = nxt;
    endtask

    function automatic int exp_out();
        if (m_state == M_PLAY && m_el >= 1) return int'(m_mem[((m_el - 1) / TDIV) % m_len]);
        return 0;
    endfunction

    task automatic check_model();
        cmp("model_ascii_out", int'(ascii_out), exp_out());
        cmp("model_recording", int'(recording), (m_state == M_REC) ? 1 : 0);
        cmp("model_playing", int'(playing), (m_state == M_PLAY) ? 1 : 0);
        cmp("model_rec_len", int'(rec_len), m_len);
        cmp("model_full", int'(full), (m_len == DEPTH) ? 1 : 0);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_model();
        end
    endtask

    function automatic row_t mk(input logic r, input logic p, input logic [6:0] a, input int n,
                                input logic [6:0] eo, input logic er, input logic ep,
                                input int el, input logic ef);
        row_t t;
        t.r = r; t.p = p; t.a = a; t.n = n;
        t.eo = eo; t.er = er; t.ep = ep; t.el = el; t.ef = ef;
        return t;
    endfunction

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        resetn     = 1'b0;
        record_req = 1'b0;
        play_req   = 1'b0;
        ascii_in   = 7'h00;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 7'h00;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_model();
        cmp("reset_rec_len", int'(rec_len), 0);
        resetn = 1'b1;

        // Empty play, record 'a','s','d', loop playback
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 3, 7'h00, 1'b0, 1'b0, 0, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h61, 5, 7'h00, 1'b1, 1'b0, 1, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h73, 4, 7'h00, 1'b1, 1'b0, 2, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h64, 4, 7'h00, 1'b1, 1'b0, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 7'h00, 1, 7'h00, 1'b0, 1'b0, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 1, 7'h00, 1'b0, 1'b1, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 1, 7'h61, 1'b0, 1'b1, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 3, 7'h61, 1'b0, 1'b1, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 1, 7'h73, 1'b0, 1'b1, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h64, 1'b0, 1'b1, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h61, 1'b0, 1'b1, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h73, 1'b0, 1'b1, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 7'h00, 1, 7'h00, 1'b0, 1'b0, 3, 1'b0));
        // Both requests from IDLE with a stored track, then overflow with 1..6
        rows.push_back(mk(1'b1, 1'b1, 7'h01, 1, 7'h00, 1'b1, 1'b0, 0, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h01, 4, 7'h00, 1'b1, 1'b0, 1, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h02, 4, 7'h00, 1'b1, 1'b0, 2, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h03, 4, 7'h00, 1'b1, 1'b0, 3, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h04, 4, 7'h00, 1'b1, 1'b0, 4, 1'b1));
        rows.push_back(mk(1'b1, 1'b0, 7'h05, 4, 7'h00, 1'b1, 1'b0, 4, 1'b1));
        rows.push_back(mk(1'b1, 1'b0, 7'h06, 4, 7'h00, 1'b1, 1'b0, 4, 1'b1));
        rows.push_back(mk(1'b0, 1'b0, 7'h00, 1, 7'h00, 1'b0, 1'b0, 4, 1'b1));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 2, 7'h01, 1'b0, 1'b1, 4, 1'b1));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h02, 1'b0, 1'b1, 4, 1'b1));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h03, 1'b0, 1'b1, 4, 1'b1));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h04, 1'b0, 1'b1, 4, 1'b1));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h01, 1'b0, 1'b1, 4, 1'b1));
        // Record request during PLAY, then re-record 3 then 2 samples (second ends on a tick)
        rows.push_back(mk(1'b1, 1'b1, 7'h00, 1, 7'h00, 1'b1, 1'b0, 0, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h78, 4, 7'h00, 1'b1, 1'b0, 1, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h79, 4, 7'h00, 1'b1, 1'b0, 2, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h7a, 4, 7'h00, 1'b1, 1'b0, 3, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 7'h00, 1, 7'h00, 1'b0, 1'b0, 3, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h71, 5, 7'h00, 1'b1, 1'b0, 1, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, 7'h77, 3, 7'h00, 1'b1, 1'b0, 1, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, 7'h77, 1, 7'h00, 1'b0, 1'b0, 2, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 2, 7'h71, 1'b0, 1'b1, 2, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h77, 1'b0, 1'b1, 2, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h71, 1'b0, 1'b1, 2, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, 7'h00, 4, 7'h77, 1'b0, 1'b1, 2, 1'b0));

        for (int i = 0; i < rows.size(); i++) begin
            record_req = rows[i].r;
            play_req   = rows[i].p;
            ascii_in   = rows[i].a;
            step(rows[i].n);
            cmp($sformatf("row%0d_ascii_out", i), int'(ascii_out), int'(rows[i].eo));
            cmp($sformatf("row%0d_recording", i), int'(recording), int'(rows[i].er));
            cmp($sformatf("row%0d_playing", i), int'(playing), int'(rows[i].ep));
            cmp($sformatf("row%0d_rec_len", i), int'(rec_len), rows[i].el);
            cmp($sformatf("row%0d_full", i), int'(full), int'(rows[i].ef));
        end

        // Asynchronous reset while playing, then play request with nothing stored
        resetn = 1'b0;
        #1;
        model_reset();
        cmp("async_reset_ascii_out", int'(ascii_out), 0);
        cmp("async_reset_playing", int'(playing), 0);
        cmp("async_reset_rec_len", int'(rec_len), 0);
        @(posedge clk);
        #1;
        resetn     = 1'b1;
        record_req = 1'b0;
        play_req   = 1'b1;
        step(3);
        cmp("post_reset_play_ignored", int'(playing), 0);
        cmp("post_reset_ascii_out", int'(ascii_out), 0);

        // Random request toggling and note codes against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) record_req = ~record_req;
            if ($urandom_range(0, 11) == 0) play_req = ~play_req;
            ascii_in = 7'($urandom);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
